// File: rtl/page_writer_pkg.sv
// Shared definitions for the UFM page write buffer: default geometry,
// erased-flash byte value and buffer state encoding.
package page_writer_pkg;

  localparam int unsigned ADDR_W_DEF    = 15;
  localparam int unsigned PAGE_LOG2_DEF = 4;
  localparam int unsigned PAGE_BYTES    = 1 << PAGE_LOG2_DEF;

  localparam logic [7:0] ERASED_BYTE = 8'hFF;

  typedef enum logic {
    ST_FILL  = 1'b0,
    ST_DRAIN = 1'b1
  } state_e;

endpackage

// File: rtl/page_mem.sv
// Page byte store: one write port, one registered read port. A same-cycle
// write to the read address is forwarded so the read sees the new byte.
module page_mem
  import page_writer_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2 = PAGE_LOG2_DEF
) (
  input  logic                  clk,
  input  logic                  we_i,
  input  logic [DEPTH_LOG2-1:0] waddr_i,
  input  logic [7:0]            wdata_i,
  input  logic [DEPTH_LOG2-1:0] raddr_i,
  output logic [7:0]            rdata_o
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

  logic [7:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    // Forwarding lets a write issued in the commit cycle land on beat 0.
    rdata_o <= (we_i && (waddr_i == raddr_i)) ? wdata_i : mem_q[raddr_i];
  end

endmodule

// File: rtl/page_writer.sv
// Random-access byte buffer for one UFM page; drains the open page as a
// sequential byte stream with a valid/ack handshake.
module page_writer
  import page_writer_pkg::*;
#(
  parameter int unsigned ADDR_W    = ADDR_W_DEF,
  parameter int unsigned PAGE_LOG2 = PAGE_LOG2_DEF
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [ADDR_W-1:0]           addr,
  input  logic [7:0]                  data_in,
  input  logic                        write_en,
  output logic                        write_rdy,
  input  logic                        commit,
  output logic [ADDR_W-PAGE_LOG2-1:0] page_addr,
  output logic [7:0]                  data_seq,
  output logic                        seq_valid,
  input  logic                        seq_ack,
  output logic                        seq_last,
  output logic                        busy
);

  localparam int unsigned PAGE_W = ADDR_W - PAGE_LOG2;
  localparam int unsigned NBYTES = 1 << PAGE_LOG2;

  state_e                state_q, state_d;
  logic [NBYTES-1:0]     valid_q, valid_d;
  logic [PAGE_LOG2-1:0]  off_q, off_d;
  logic [PAGE_W-1:0]     page_q, page_d;

  logic [PAGE_LOG2-1:0]  wr_off;
  logic [PAGE_W-1:0]     wr_page;
  logic                  any_valid;
  logic                  page_miss;
  logic                  wr_acc;
  logic                  drain_req;
  logic                  xfer;
  logic                  last_xfer;
  logic [7:0]            rd_data;

  assign wr_off    = addr[PAGE_LOG2-1:0];
  assign wr_page   = addr[ADDR_W-1:PAGE_LOG2];
  assign any_valid = |valid_q;
  assign page_miss = any_valid && (wr_page != page_q);

  assign wr_acc    = write_en && write_rdy;
  assign xfer      = seq_valid && seq_ack;
  assign last_xfer = xfer && seq_last;

  // A write arriving with the commit counts toward "page has content";
  // a write to a foreign page forces a drain of the open one.
  assign drain_req = (state_q == ST_FILL) &&
                     ((commit && (any_valid || wr_acc)) || (write_en && page_miss));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_FILL;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_FILL:  if (drain_req) state_d = ST_DRAIN;
      ST_DRAIN: if (last_xfer) state_d = ST_FILL;
      default:  state_d = ST_FILL;
    endcase
  end

  always_comb begin
    busy      = (state_q == ST_DRAIN);
    seq_valid = busy;
    seq_last  = busy && (off_q == '1);
    write_rdy = (state_q == ST_FILL) && !(write_en && page_miss);
    data_seq  = (busy && valid_q[off_q]) ? rd_data : ERASED_BYTE;
    page_addr = page_q;
  end

  always_comb begin
    valid_d = valid_q;
    page_d  = page_q;
    off_d   = off_q;
    if (wr_acc) begin
      valid_d[wr_off] = 1'b1;
      if (!any_valid) begin
        page_d = wr_page;
      end
    end
    if (xfer) begin
      off_d = off_q + PAGE_LOG2'(1);
    end
    if (last_xfer) begin
      valid_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      off_q   <= '0;
      page_q  <= '0;
    end else begin
      valid_q <= valid_d;
      off_q   <= off_d;
      page_q  <= page_d;
    end
  end

  // Read address tracks the offset of the next cycle so the registered
  // read byte lines up with off_q.
  page_mem #(
    .DEPTH_LOG2(PAGE_LOG2)
  ) u_mem (
    .clk     (clk),
    .we_i    (wr_acc),
    .waddr_i (wr_off),
    .wdata_i (data_in),
    .raddr_i (off_d),
    .rdata_o (rd_data)
  );

endmodule

// File: tb/tb_page_writer.sv
// Self-checking bench for page_writer: directed scenarios plus randomized
// pages checked against a byte/valid-mask reference model.
module tb_page_writer;
  import page_writer_pkg::*;

  localparam int unsigned AW = 15;
  localparam int unsigned PL = 4;
  localparam int unsigned PW = AW - PL;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] addr;
  logic [7:0]    data_in;
  logic          write_en;
  logic          write_rdy;
  logic          commit;
  logic [PW-1:0] page_addr;
  logic [7:0]    data_seq;
  logic          seq_valid;
  logic          seq_ack;
  logic          seq_last;
  logic          busy;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  // Reference model: page content as bytes plus a written-mask.
  logic [7:0]            m_mem [PAGE_BYTES];
  logic [PAGE_BYTES-1:0] m_valid = '0;
  logic [PW-1:0]         m_page  = '0;

  always #5 clk = ~clk;

  page_writer #(.ADDR_W(AW), .PAGE_LOG2(PL)) dut (
    .clk       (clk),
    .rst       (rst),
    .addr      (addr),
    .data_in   (data_in),
    .write_en  (write_en),
    .write_rdy (write_rdy),
    .commit    (commit),
    .page_addr (page_addr),
    .data_seq  (data_seq),
    .seq_valid (seq_valid),
    .seq_ack   (seq_ack),
    .seq_last  (seq_last),
    .busy      (busy)
  );

  function automatic void model_write(input logic [AW-1:0] a, input logic [7:0] d);
    if (m_valid == '0) m_page = a[AW-1:PL];
    m_mem[a[PL-1:0]] = d;
    m_valid[a[PL-1:0]] = 1'b1;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_write(input logic [AW-1:0] a, input logic [7:0] d, input logic c);
    addr = a; data_in = d; write_en = 1'b1; commit = c;
    @(negedge clk);
    n_cmp++;
    if (write_rdy !== 1'b1) begin
      n_err++; $display("FAIL write_rdy_accept addr %h: got %b want 1", a, write_rdy);
    end
    step();
    write_en = 1'b0; commit = 1'b0;
    model_write(a, d);
  endtask

  task automatic do_commit();
    commit = 1'b1;
    step();
    commit = 1'b0;
  endtask

  // Entered one cycle after the commit edge; mode 0 = always ack,
  // 1 = ack every third cycle, 2 = random ack.
  task automatic drain_check(input string name, input int mode);
    logic [7:0] exp_b [PAGE_BYTES];
    logic [7:0] hd;
    logic       hl;
    bit         held = 0;
    int         beat = 0;
    int         cyc  = 0;
    for (int i = 0; i < int'(PAGE_BYTES); i++)
      exp_b[i] = m_valid[i] ? m_mem[i] : 8'hFF;
    hd = 8'h00; hl = 1'b0;
    while (beat < int'(PAGE_BYTES) && cyc < 200) begin
      case (mode)
        0:       seq_ack = 1'b1;
        1:       seq_ack = ((cyc % 3) == 2);
        default: seq_ack = 1'($urandom_range(0, 1));
      endcase
      @(negedge clk);
      n_cmp++;
      if (seq_valid !== 1'b1) begin
        n_err++; $display("FAIL %s seq_valid cycle %0d beat %0d: got %b want 1", name, cyc, beat, seq_valid);
        break;
      end
      n_cmp++;
      if (busy !== 1'b1 || page_addr !== m_page) begin
        n_err++; $display("FAIL %s busy/page_addr: got %b/%h want 1/%h", name, busy, page_addr, m_page);
      end
      if (held) begin
        n_cmp++;
        if (data_seq !== hd || seq_last !== hl) begin
          n_err++; $display("FAIL %s hold beat %0d: got %h/%b want %h/%b", name, beat, data_seq, seq_last, hd, hl);
        end
      end
      if (seq_ack) begin
        n_cmp++;
        if (data_seq !== exp_b[beat]) begin
          n_err++; $display("FAIL %s data beat %0d: got %h want %h", name, beat, data_seq, exp_b[beat]);
        end
        n_cmp++;
        if (seq_last !== (beat == int'(PAGE_BYTES) - 1)) begin
          n_err++; $display("FAIL %s seq_last beat %0d: got %b want %b", name, beat, seq_last, beat == int'(PAGE_BYTES) - 1);
        end
        beat++;
        held = 0;
      end else begin
        held = 1; hd = data_seq; hl = seq_last;
      end
      step();
      cyc++;
    end
    seq_ack = 1'b0;
    n_cmp++;
    if (beat != int'(PAGE_BYTES)) begin
      n_err++; $display("FAIL %s beat_count: got %0d want %0d", name, beat, PAGE_BYTES);
    end
    if (mode == 0) begin
      n_cmp++;
      if (cyc != int'(PAGE_BYTES)) begin
        n_err++; $display("FAIL %s throughput cycles: got %0d want %0d", name, cyc, PAGE_BYTES);
      end
    end
    @(negedge clk);
    n_cmp++;
    if (seq_valid !== 1'b0 || busy !== 1'b0 || write_rdy !== 1'b1) begin
      n_err++; $display("FAIL %s post_drain valid/busy/rdy: got %b/%b/%b want 0/0/1", name, seq_valid, busy, write_rdy);
    end
    m_valid = '0;
    step();
  endtask

  task automatic check_idle(input string name);
    @(negedge clk);
    n_cmp++;
    if (seq_valid !== 1'b0 || busy !== 1'b0 || seq_last !== 1'b0 ||
        write_rdy !== 1'b1 || data_seq !== 8'hFF) begin
      n_err++; $display("FAIL %s idle valid/busy/last/rdy/data: got %b/%b/%b/%b/%h want 0/0/0/1/ff",
                        name, seq_valid, busy, seq_last, write_rdy, data_seq);
    end
    step();
  endtask

  task automatic test_reset();
    rst = 1'b1; addr = '0; data_in = '0; write_en = 1'b0; commit = 1'b0; seq_ack = 1'b0;
    repeat (3) step();
    @(negedge clk);
    n_cmp++;
    if (page_addr !== '0) begin
      n_err++; $display("FAIL reset page_addr: got %h want 0", page_addr);
    end
    step();
    rst = 1'b0;
    check_idle("reset");
  endtask

  task automatic test_full_page();
    for (int i = 0; i < 16; i++) drive_write(AW'(16 + i), 8'(i), 1'b0);
    do_commit();
    drain_check("full_page", 0);
  endtask

  task automatic test_single_byte();
    drive_write(AW'('h23), 8'h5A, 1'b0);
    do_commit();
    drain_check("single_byte", 0);
  endtask

  task automatic test_backpressure();
    for (int i = 0; i < 16; i++) drive_write(AW'(16 + i), 8'(i), 1'b0);
    do_commit();
    drain_check("backpressure", 1);
  endtask

  task automatic test_auto_commit();
    drive_write(AW'('h05), 8'h11, 1'b0);
    addr = AW'('h35); data_in = 8'h22; write_en = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (write_rdy !== 1'b0) begin
      n_err++; $display("FAIL auto_commit write_rdy: got %b want 0", write_rdy);
    end
    step();
    drain_check("auto_commit_p0", 0);
    write_en = 1'b0;
    model_write(AW'('h35), 8'h22);
    do_commit();
    drain_check("auto_commit_p3", 0);
  endtask

  task automatic test_empty_commit_and_reset();
    do_commit();
    repeat (3) check_idle("empty_commit");
    for (int i = 0; i < 4; i++)
      drive_write({PW'(7), PL'($urandom_range(0, 15))}, 8'($urandom), 1'b0);
    do_commit();
    seq_ack = 1'b1;
    repeat (5) step();
    seq_ack = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    m_valid = '0; m_page = '0;
    @(negedge clk);
    n_cmp++;
    if (page_addr !== '0) begin
      n_err++; $display("FAIL reset_mid_drain page_addr: got %h want 0", page_addr);
    end
    step();
    check_idle("reset_mid_drain");
    do_commit();
    check_idle("commit_after_reset");
  endtask

  task automatic test_commit_with_write();
    drive_write(AW'('h02), 8'hAA, 1'b1);
    drain_check("commit_same_cycle", 0);
  endtask

  task automatic test_random();
    for (int it = 0; it < 6; it++) begin
      logic [PW-1:0] pg;
      int            n;
      bit            joined;
      pg = PW'($urandom_range(0, (1 << PW) - 1));
      n  = $urandom_range(1, 24);
      joined = 1'($urandom_range(0, 1));
      for (int k = 0; k < n; k++)
        drive_write({pg, PL'($urandom_range(0, 15))}, 8'($urandom),
                    (k == n - 1) && joined);
      if (!joined) do_commit();
      drain_check("random", 2);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_full_page();
    test_single_byte();
    test_backpressure();
    test_auto_commit();
    test_empty_commit_and_reset();
    test_commit_with_write();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/page_writer.md
PAGE_WRITER -- requirements
Module: page_writer

Interface
REQ-001 Parameter ADDR_W, default 15, byte address width of UFM space.
REQ-002 Parameter PAGE_LOG2, default 4, log2 bytes per page (16-byte UFM page).
REQ-003 clk  in  1  clock; all logic on rising edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 addr  in  ADDR_W  byte address of random-access write.
REQ-006 data_in  in  8  write data.
REQ-007 write_en  in  1  write request; accepted when write_en && write_rdy.
REQ-008 write_rdy  out  1  buffer accepts a write this cycle.
REQ-009 commit  in  1  request drain of the open page to flash side.
REQ-010 page_addr  out  ADDR_W-PAGE_LOG2  page number of the page being drained; stable while busy.
REQ-011 data_seq  out  8  sequential page byte, offset 0 first.
REQ-012 seq_valid  out  1  data_seq valid; transfer on seq_valid && seq_ack.
REQ-013 seq_ack  in  1  downstream (UFM programmer) accepts current byte.
REQ-014 seq_last  out  1  high with the byte at offset 2^PAGE_LOG2-1.
REQ-015 busy  out  1  high in DRAIN state.

Function
REQ-016 States: FILL and DRAIN only; reset enters FILL.
REQ-017 FILL: write_rdy = 1 unless stalled per REQ-020; DRAIN: write_rdy = 0, writes ignored.
REQ-018 Accepted write stores data_in at offset addr[PAGE_LOG2-1:0] and sets that byte's valid bit.
REQ-019 First accepted write with all valid bits clear latches addr[ADDR_W-1:PAGE_LOG2] as open page.
REQ-020 Write to a different page while any valid bit set: write_rdy = 0 that cycle, auto-commit issued, write held off until return to FILL.
REQ-021 commit in FILL with any valid bit set -> DRAIN next cycle; commit with no valid bits -> ignored, stays FILL.
REQ-022 commit and accepted write same cycle: write is included in the drained page.
REQ-023 First seq_valid asserts exactly one cycle after the commit cycle, carrying offset 0.
REQ-024 data_seq, seq_last hold stable while seq_valid && !seq_ack; no byte dropped or repeated.
REQ-025 Each transfer advances offset by 1; after transfer with seq_last, next cycle: seq_valid = 0, all valid bits clear, state FILL.
REQ-026 Bytes with valid bit clear output 8'hFF (erased value); a page is always exactly 2^PAGE_LOG2 beats.
REQ-027 Throughput: with seq_ack held high, one byte per cycle; full page drains in 16 cycles after the first.
REQ-028 Repeated writes to same offset before commit: last write wins.
REQ-029 Offset counter is PAGE_LOG2 bits; wrap from 15 to 0 coincides with leaving DRAIN.

Reset
REQ-030 rst: state FILL, valid bits 0, offset 0, seq_valid 0, seq_last 0, busy 0, write_rdy 1, page_addr 0, data_seq 8'hFF.
REQ-031 rst mid-DRAIN aborts drain; partial page discarded; no seq_valid in the cycle after rst.
REQ-032 Storage array contents need not be reset; valid mask alone defines content.

Structure
REQ-033 Shared package holds PAGE_BYTES, default ADDR_W/PAGE_LOG2, ERASED_BYTE = 8'hFF, state encoding.
REQ-034 One sub-module page_mem: 2^PAGE_LOG2 x 8, one write port, one registered read port.
REQ-035 Valid mask, state machine, offset counter, and handshake stay in page_writer.

Verification
REQ-036 Write 0x00..0x0F to addr 0x0010..0x001F, commit, seq_ack=1 -> page_addr 1, bytes 0x00..0x0F in 16 cycles, seq_last on 16th.
REQ-037 Write only addr 0x0023=0x5A, commit -> page_addr 2, 16 beats, offset 3 = 0x5A, others 0xFF.
REQ-038 Drain with seq_ack toggled 1-of-3 cycles -> same 16-byte sequence, data stable while unacked.
REQ-039 Write 0x0005=0x11 then 0x0035=0x22 -> write_rdy low, page 0 drains (0x11 at offset 5), then 0x22 accepted into page 3.
REQ-040 Commit with no writes -> busy stays 0, no seq_valid; rst asserted after 5th beat -> seq_valid 0, next commit ignored.
REQ-041 Write 0x0002=0xAA and commit same cycle -> offset 2 drains as 0xAA.
